mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates a single unified memory port between the CPU's instruction-fetch side and its data side. The multicycle CPU variant uses it in place of separate instruction and data memories. Each side makes a blocking request and receives a one-cycle Ready pulse. Data requests have priority, and a bounded-streak rule guarantees fetch progress. Memory is word-addressed at the port level with a registered (1-cycle) read.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_D_STREAK, 4, max consecutive D grants while IReq is pending; range 1..15
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-low reset
- IReq  in  1  fetch request; held until IReady
- IAddr  in  AW  fetch address
- IReady  out  1  one-cycle completion pulse for fetch
- IRdata  out  DW  fetch data, valid only while IReady=1
- DReq  in  1  data request; held until DReady
- DWe  in  1  1 = write, 0 = read
- DAddr  in  AW  data address
- DWdata  in  DW  write data
- DReady  out  1  one-cycle completion pulse for data
- DRdata  out  DW  read data, valid only while DReady=1 with a read
- MemEn  out  1  memory access strobe
- MemWe  out  1  memory write enable, only with MemEn
- MemAddr  out  AW  memory address
- MemWdata  out  DW  memory write data
- MemRdata  in  DW  read data, valid the cycle after MemEn

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE → ISSUE when any request is present. Grant rule, in order:
  - if IReq and streak==MAX_D_STREAK, grant I;
  - else if DReq, grant D;
  - else if IReq, grant I.
- IDLE with no request: stay in IDLE.
- On grant, register the grant ID, address, DWe, and DWdata. Requester changes after the grant are ignored until the next grant.
- ISSUE: MemEn=1, MemAddr = latched address. MemWe = latched DWe for a D grant, else 0. MemWdata = latched DWdata. Next state RESP.
- RESP: assert the granted side's Ready for exactly one cycle.
  - IRdata/DRdata = MemRdata for reads.
  - DRdata is don't-care for writes.
  - Next state is always IDLE.
- Streak counter (4 bits), updated at grant:
  - D granted with IReq=1: increment.
  - D granted with IReq=0: clear.
  - I granted: clear.
- A requester that drops Req before its Ready still gets its access completed and Ready pulsed.
- The I side never produces MemWe=1.

## Timing
- Request visible in IDLE at cycle t → MemEn at t+1 → Ready at t+2 → back in IDLE at t+3, where the next grant is decided.
- Throughput: one access per 3 cycles.
- Requester may deassert Req or present a new request from t+3. A still-asserted Req at t+3 is treated as a new request.
- Reset (Rst=0 at a rising edge) gives, from the next cycle:
  - state IDLE, streak 0;
  - MemEn=0, MemWe=0, IReady=0, DReady=0;
  - MemAddr, MemWdata, IRdata, DRdata = 0.
- Reset mid-ISSUE or mid-RESP aborts the access with no Ready pulse. A write in ISSUE is suppressed if reset is asserted in that cycle.
- Simultaneous IReq and DReq in IDLE with streak<MAX: D wins.
- At most one Ready is high in any cycle. MemEn is never high in consecutive cycles.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - grant constants GNT_I=0, GNT_D=1;
  - default AW/DW.
- Sub-module arb_grant: purely combinational grant selection from IReq, DReq, and streak. Small, but it isolates the priority rule for unit test.
- Top-level mem_arbiter holds the FSM, request latches, and streak counter.

## Test plan
- I-only read: IReq=1, IAddr=0x10, memory returns 0xE3A00005 → MemEn=1 with MemAddr=0x10 and MemWe=0 at t+1; IReady=1, IRdata=0xE3A00005 at t+2; DReady stays 0.
- Simultaneous read: IReq (0x20) and DReq read (0x80) at t → D served first (MemAddr=0x80 at t+1, DReady at t+2); I granted at t+3 (MemAddr=0x20 at t+4, IReady at t+5).
- D write: DWe=1, DAddr=0x100, DWdata=0xDEADBEEF → MemWe=1, MemWdata=0xDEADBEEF at t+1 only; DReady at t+2; subsequent D read of 0x100 returns 0xDEADBEEF from the memory model.
- Starvation bound, MAX_D_STREAK=4: DReq and IReq held high continuously → grant sequence D,D,D,D,I,D…; IReady follows the 4th DReady by 3 cycles.
- Reset mid-access: Rst=0 during ISSUE of a D write → MemWe=0 that cycle's successor, no DReady. After Rst=1 with DReq still high, the write reissues from IDLE with normal t+1/t+2 timing.
- Idle: no requests for 20 cycles → MemEn, MemWe, IReady, DReady all 0 throughout; streak stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Combinational grant selection: data side has priority unless the fetch side
// has waited out a full D streak.
module arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic       ireq,
  input  logic       dreq,
  input  logic [3:0] streak,
  output logic       valid,
  output logic       gnt
);

  always_comb begin
    valid = ireq | dreq;
    gnt   = GNT_I;
    if (ireq && (streak == 4'(MAX_D_STREAK)))
      gnt = GNT_I;
    else if (dreq)
      gnt = GNT_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read memory port between fetch and data requesters;
// one access per three cycles (IDLE -> ISSUE -> RESP).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          IReq,
  input  logic [AW-1:0] IAddr,
  output logic          IReady,
  output logic [DW-1:0] IRdata,
  input  logic          DReq,
  input  logic          DWe,
  input  logic [AW-1:0] DAddr,
  input  logic [DW-1:0] DWdata,
  output logic          DReady,
  output logic [DW-1:0] DRdata,
  output logic          MemEn,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata
);

  state_t     state;
  logic [3:0] streak;
  logic       gnt_q;
  logic       we_q;
  logic       en_q;
  logic       mwe_q;
  logic       gnt_valid;
  logic       gnt;

  arb_grant #(.MAX_D_STREAK(MAX_D_STREAK)) u_grant (
    .ireq   (IReq),
    .dreq   (DReq),
    .streak (streak),
    .valid  (gnt_valid),
    .gnt    (gnt)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      streak   <= '0;
      gnt_q    <= GNT_I;
      we_q     <= 1'b0;
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      MemAddr  <= '0;
      MemWdata <= '0;
      IReady   <= 1'b0;
      DReady   <= 1'b0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      en_q   <= 1'b0;
      mwe_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt_q    <= gnt;
            we_q     <= (gnt == GNT_D) && DWe;
            en_q     <= 1'b1;
            mwe_q    <= (gnt == GNT_D) && DWe;
            MemAddr  <= (gnt == GNT_D) ? DAddr : IAddr;
            MemWdata <= DWdata;
            if ((gnt == GNT_D) && IReq)
              streak <= streak + 4'd1;
            else
              streak <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          IReady <= (gnt_q == GNT_I);
          DReady <= (gnt_q == GNT_D);
          state  <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are registered but gated by Rst so a reset in ISSUE kills the write
  // at the very edge the memory would have sampled it.
  assign MemEn  = en_q & Rst;
  assign MemWe  = mwe_q & Rst;

  // Registered-read data arrives during RESP, the same cycle as Ready.
  assign IRdata = IReady ? MemRdata : '0;
  assign DRdata = (DReady && !we_q) ? MemRdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small registered-read memory model.
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IReady;
  logic [31:0] IRdata;
  logic        DReq;
  logic        DWe;
  logic [31:0] DAddr;
  logic [31:0] DWdata;
  logic        DReady;
  logic [31:0] DRdata;
  logic        MemEn;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [31:0] MemRdata;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  logic [31:0] mem [0:1023];

  mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .IReq     (IReq),
    .IAddr    (IAddr),
    .IReady   (IReady),
    .IRdata   (IRdata),
    .DReq     (DReq),
    .DWe      (DWe),
    .DAddr    (DAddr),
    .DWdata   (DWdata),
    .DReady   (DReady),
    .DRdata   (DRdata),
    .MemEn    (MemEn),
    .MemWe    (MemWe),
    .MemAddr  (MemAddr),
    .MemWdata (MemWdata),
    .MemRdata (MemRdata)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (MemEn) begin
      if (MemWe) mem[MemAddr[9:0]] <= MemWdata;
      MemRdata <= mem[MemAddr[9:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 32'hE3A00005;
    mem[10'h020] = 32'hCAFEF00D;
    mem[10'h080] = 32'h12345678;
    MemRdata = '0;
    Rst = 1'b0; IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWdata = '0;

    // Reset state
    step(); step();
    check("rst_memen",  {31'b0, MemEn},  32'd0);
    check("rst_memwe",  {31'b0, MemWe},  32'd0);
    check("rst_iready", {31'b0, IReady}, 32'd0);
    check("rst_dready", {31'b0, DReady}, 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    check("rst_memwdata", MemWdata, 32'd0);
    check("rst_irdata", IRdata, 32'd0);
    check("rst_drdata", DRdata, 32'd0);
    Rst = 1'b1;

    // Idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_strobes", {28'b0, MemEn, MemWe, IReady, DReady}, 32'd0);
      check("idle_streak", {28'b0, dut.streak}, 32'd0);
    end

    // I-only read
    IReq = 1'b1; IAddr = 32'h10;
    step();
    check("iread_memen", {31'b0, MemEn}, 32'd1);
    check("iread_memaddr", MemAddr, 32'h10);
    check("iread_memwe", {31'b0, MemWe}, 32'd0);
    step();
    check("iread_iready", {31'b0, IReady}, 32'd1);
    check("iread_irdata", IRdata, 32'hE3A00005);
    check("iread_dready", {31'b0, DReady}, 32'd0);
    IReq = 1'b0;
    step();
    check("iread_done", {30'b0, MemEn, IReady}, 32'd0);

    // Simultaneous I and D read: D first
    IReq = 1'b1; IAddr = 32'h20; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h80;
    step();
    check("sim_d_memen", {31'b0, MemEn}, 32'd1);
    check("sim_d_memaddr", MemAddr, 32'h80);
    step();
    check("sim_d_ready", {30'b0, IReady, DReady}, 32'd1);
    check("sim_d_rdata", DRdata, 32'h12345678);
    DReq = 1'b0;
    step();
    check("sim_gap_memen", {31'b0, MemEn}, 32'd0);
    step();
    check("sim_i_memen", {31'b0, MemEn}, 32'd1);
    check("sim_i_memaddr", MemAddr, 32'h20);
    step();
    check("sim_i_ready", {30'b0, IReady, DReady}, 32'd2);
    check("sim_i_rdata", IRdata, 32'hCAFEF00D);
    IReq = 1'b0;
    step();

    // D write then read back
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h100; DWdata = 32'hDEADBEEF;
    step();
    check("wr_memen_we", {30'b0, MemEn, MemWe}, 32'd3);
    check("wr_memaddr", MemAddr, 32'h100);
    check("wr_memwdata", MemWdata, 32'hDEADBEEF);
    step();
    check("wr_after_strobes", {30'b0, MemEn, MemWe}, 32'd0);
    check("wr_dready", {31'b0, DReady}, 32'd1);
    DWe = 1'b0;
    step();
    check("rd_gap_memen", {31'b0, MemEn}, 32'd0);
    step();
    check("rd_memen_we", {30'b0, MemEn, MemWe}, 32'd2);
    check("rd_memaddr", MemAddr, 32'h100);
    step();
    check("rd_dready", {31'b0, DReady}, 32'd1);
    check("rd_drdata", DRdata, 32'hDEADBEEF);
    DReq = 1'b0;
    step();

    // Starvation bound: both held, expect D,D,D,D,I,D
    IReq = 1'b1; IAddr = 32'h10; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h80;
    for (int c = 1; c <= 17; c++) begin
      step();
      check("starve_iready", {31'b0, IReady}, (c == 14) ? 32'd1 : 32'd0);
      check("starve_dready", {31'b0, DReady}, ((c % 3 == 2) && (c != 14)) ? 32'd1 : 32'd0);
      if (c == 14) check("starve_irdata", IRdata, 32'hE3A00005);
    end
    IReq = 1'b0; DReq = 1'b0;
    step();

    // Reset during ISSUE of a D write
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h140; DWdata = 32'h55AA55AA;
    step();
    check("rstmid_issue_we", {31'b0, MemWe}, 32'd1);
    Rst = 1'b0;
    #1;
    check("rstmid_we_gated", {30'b0, MemEn, MemWe}, 32'd0);
    step();
    check("rstmid_after", {28'b0, MemEn, MemWe, IReady, DReady}, 32'd0);
    check("rstmid_nowrite", mem[10'h140], 32'd0);
    Rst = 1'b1;
    step();
    check("reissue_memen_we", {30'b0, MemEn, MemWe}, 32'd3);
    check("reissue_memaddr", MemAddr, 32'h140);
    step();
    check("reissue_dready", {30'b0, IReady, DReady}, 32'd1);
    check("reissue_written", mem[10'h140], 32'h55AA55AA);
    DReq = 1'b0; DWe = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
